memory_access_ctrl: RTL
=======================

MEMORY_ACCESS_CTRL -- requirements
Module: memory_access_ctrl

Interface
REQ-001 Parameter DATA_W, default 32: data bus and register width in bits; SHALL be a multiple of 8, at least 8.
REQ-002 Parameter ADDR_W, default 32: address width in bits.
REQ-003 Parameter TIMEOUT, default 15: maximum wait cycles allowed for mem_ack before the access faults; range 1..255.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 start  in  1  request from the core; sampled only in IDLE.
REQ-008 op_code  in  4  1101 = LDR, 1110 = STR, any other value = instruction fetch.
REQ-009 sr1  in  ADDR_W  load/store address.
REQ-010 sr2  in  DATA_W  store data.
REQ-011 pc  in  ADDR_W  fetch address.
REQ-012 mem_ack  in  1  memory completion; mem_rdata is valid in the same cycle.
REQ-013 mem_rdata  in  DATA_W  read data from memory.
REQ-014 mem_req  out  1  memory request; held until ack or timeout.
REQ-015 rw  out  1  1 = read, 0 = write; valid while mem_req is high.
REQ-016 add_bus  out  ADDR_W  registered access address.
REQ-017 data_bus  out  DATA_W  registered store data.
REQ-018 ldr, str  out  1 each  registered operation flags for the current access.
REQ-019 data_reg  out  DATA_W  last load result.
REQ-020 instr_reg  out  DATA_W  last fetched instruction.
REQ-021 busy, done, fault  out  1 each  busy = not IDLE; done = one-cycle completion pulse; fault = error flag for the completed access.

Function
REQ-022 States SHALL be IDLE, REQ, DONE; the one-hot or binary encoding is free.
REQ-023 IDLE with start=1: latch op_code, sr2 and the address (sr1 for LDR/STR, pc otherwise), set ldr/str/rw, go to REQ, and clear fault.
REQ-024 rw SHALL be 1 for LDR and fetch, and 0 for STR.
REQ-025 REQ: mem_req=1; add_bus, data_bus and rw SHALL stay stable until exit.
REQ-026 REQ with mem_ack=1: capture mem_rdata into data_reg (LDR) or instr_reg (fetch); STR captures nothing; go to DONE.
REQ-027 The wait counter SHALL clear on entry to REQ and increment on each REQ cycle without mem_ack.
REQ-028 When the counter equals TIMEOUT with no ack, the block SHALL set fault=1, capture no data and go to DONE.
REQ-029 mem_ack and the timeout in the same cycle: ack SHALL win and fault stays 0.
REQ-030 DONE: done=1 for exactly one cycle, mem_req=0, then return to IDLE.
REQ-031 Latency: start accepted at edge t gives mem_req high after t; ack at the k-th REQ cycle (k>=1) gives done in cycle k+1 after t. Minimum start-to-done is 2 cycles.
REQ-032 start outside IDLE SHALL be ignored; mem_ack outside REQ SHALL be ignored.
REQ-033 The counter SHALL saturate and never wrap.
REQ-034 data_reg, instr_reg and fault SHALL hold until overwritten; fault is overwritten only on the next accepted start.

Reset
REQ-035 rst=1 at a clock edge SHALL force IDLE, with every output and internal register at 0, including mid-access; mem_req drops in the following cycle.
REQ-036 rst SHALL take priority over start and mem_ack.

Configuration
REQ-037 With MEM_ALIGN_CHECK_EN defined, an access whose address low log2(DATA_W/8) bits are nonzero SHALL skip REQ (no mem_req), go directly to DONE with fault=1, and capture no data.
REQ-038 Without MEM_ALIGN_CHECK_EN, no alignment check is performed and any address is issued.

Structure
REQ-039 Package mem_ctrl_pkg SHALL hold OP_LDR=4'b1101, OP_STR=4'b1110, the state typedef, and the counter width constant (8 bits).
REQ-040 One sub-module, wait_timer (clear, enable, saturating count, expired flag compared against TIMEOUT), SHALL implement the timeout.

Verification
REQ-041 Fetch: pc=0x0000_0040, start, ack on the 1st REQ cycle with rdata=0xE3A0_1005 -> rw=1, add_bus=0x40, instr_reg=0xE3A01005, done at cycle 2, fault=0.
REQ-042 LDR: op=1101, sr1=0x100, ack after 3 waits with rdata=0xDEADBEEF -> data_reg=0xDEADBEEF, done at cycle 5.
REQ-043 STR: op=1110, sr1=0x200, sr2=0x12345678 -> rw=0, data_bus=0x12345678, data_reg unchanged.
REQ-044 Timeout: no ack with TIMEOUT=15 -> mem_req high for 15 cycles, then done=1 and fault=1; ack arriving in cycle 15 -> fault=0.
REQ-045 rst asserted in the 2nd REQ cycle -> next cycle IDLE with all outputs 0; start during busy is ignored.
REQ-046 With MEM_ALIGN_CHECK_EN and sr1=0x102 for LDR -> no mem_req, done at cycle 1, fault=1.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared opcodes, FSM state type and wait-counter width for memory_access_ctrl.
package mem_ctrl_pkg;

   localparam logic [3:0] OP_LDR = 4'b1101;
   localparam logic [3:0] OP_STR = 4'b1110;
   localparam int         CNT_W  = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/memory_access_ctrl_wait_timer.sv
// Saturating wait counter for the memory handshake; flags expiry on the cycle
// whose increment would reach TIMEOUT, so the request lasts exactly TIMEOUT cycles.
module wait_timer
   import mem_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_inc;

   assign count_inc = (count == '1) ? count : count + CNT_W'(1);
   assign expired   = enable && (count_inc == CNT_W'(TIMEOUT));

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count_inc;
      end
   end

endmodule

// File: rtl/memory_access_ctrl.sv
// Single-access memory controller: fetch / load / store with ack timeout.
// Optional alignment fault on load/store/fetch addresses: MEM_ALIGN_CHECK_EN.
//
//   state | meaning
//   IDLE  | waiting for start, last results held
//   REQ   | mem_req asserted, waiting for mem_ack or timeout
//   DONE  | one-cycle done pulse, then back to IDLE
module memory_access_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [3:0]        op_code,
   input  logic [ADDR_W-1:0] sr1,
   input  logic [DATA_W-1:0] sr2,
   input  logic [ADDR_W-1:0] pc,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_req,
   output logic              rw,
   output logic [ADDR_W-1:0] add_bus,
   output logic [DATA_W-1:0] data_bus,
   output logic              ldr,
   output logic              str,
   output logic [DATA_W-1:0] data_reg,
   output logic [DATA_W-1:0] instr_reg,
   output logic              busy,
   output logic              done,
   output logic              fault
);

   state_t            state;
   logic              op_ldr;
   logic              op_str;
   logic [ADDR_W-1:0] start_addr;
   logic              misaligned;
   logic              timer_expired;

   assign op_ldr     = (op_code == OP_LDR);
   assign op_str     = (op_code == OP_STR);
   assign start_addr = (op_ldr || op_str) ? sr1 : pc;

`ifdef MEM_ALIGN_CHECK_EN
   localparam int                ALIGN_BITS = $clog2(DATA_W / 8);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((64'd1 << ALIGN_BITS) - 64'd1);
   assign misaligned = |(start_addr & ALIGN_MASK);
`else
   assign misaligned = 1'b0;
`endif

   wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (state != REQ),
      .enable  ((state == REQ) && !mem_ack),
      .expired (timer_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         mem_req   <= 1'b0;
         rw        <= 1'b0;
         add_bus   <= '0;
         data_bus  <= '0;
         ldr       <= 1'b0;
         str       <= 1'b0;
         data_reg  <= '0;
         instr_reg <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         fault     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  add_bus  <= start_addr;
                  data_bus <= sr2;
                  ldr      <= op_ldr;
                  str      <= op_str;
                  rw       <= !op_str;
                  busy     <= 1'b1;
                  if (misaligned) begin
                     fault <= 1'b1;
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     fault   <= 1'b0;
                     mem_req <= 1'b1;
                     state   <= REQ;
                  end
               end
            end
            REQ: begin
               // ack beats a simultaneous expiry, so check it first
               if (mem_ack) begin
                  if (ldr) begin
                     data_reg <= mem_rdata;
                  end else if (!str) begin
                     instr_reg <= mem_rdata;
                  end
                  mem_req <= 1'b0;
                  done    <= 1'b1;
                  state   <= DONE;
               end else if (timer_expired) begin
                  fault   <= 1'b1;
                  mem_req <= 1'b0;
                  done    <= 1'b1;
                  state   <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               mem_req <= 1'b0;
               done    <= 1'b0;
               busy    <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule
